// File: rtl/wb_qspi_pkg.sv
// Shared types and defaults for the QSPI upstream arbiter (wb_qspi_arb).
package wb_qspi_pkg;

    localparam int unsigned RAM_SEL_BIT_DEF = 24;
    localparam int unsigned MEM_ADR_W_DEF   = 22;
    localparam int unsigned DAT_W           = 32;
    localparam int unsigned BE_W            = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {IBUS, DBUS} owner_t;

    // Request latch payload; the word address is kept beside it because its width is a parameter.
    typedef struct packed {
        logic            sel;
        logic            we;
        logic [BE_W-1:0] be;
        logic [DAT_W-1:0] dat;
    } req_t;

endpackage

// File: rtl/wb_qspi_ibuf.sv
// One-entry instruction word buffer: tag/valid/data with lookup, fill and invalidate.
module wb_qspi_ibuf
    import wb_qspi_pkg::*;
#(
    parameter int unsigned TAG_W = MEM_ADR_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit_c,
    output logic [DAT_W-1:0] hit_dat,
    input  logic             fill,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [DAT_W-1:0] fill_dat,
    input  logic             inval,
    input  logic [TAG_W-1:0] inval_tag
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [DAT_W-1:0] data_q;

    // Fill and invalidate never coincide: they come from different bus owners.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
            data_q  <= fill_dat;
        end else if (inval && (tag_q == inval_tag)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_c   = valid_q && (tag_q == lookup_tag);
    assign hit_dat = data_q;

endmodule

// File: rtl/wb_qspi_arb.sv
// Arbitrates CPU ibus/dbus onto the QSPI controller, one held transaction at a time.
// Optional one-word fetch buffer enabled by defining WB_QSPI_ARB_IBUF_EN.
module wb_qspi_arb
    import wb_qspi_pkg::*;
#(
    parameter int unsigned RAM_SEL_BIT = RAM_SEL_BIT_DEF,
    parameter int unsigned MEM_ADR_W   = MEM_ADR_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ibus_stb_i,
    input  logic [31:0]          ibus_adr_i,
    output logic                 ibus_ack_o,
    output logic [31:0]          ibus_dat_o,
    input  logic                 dbus_stb_i,
    input  logic                 dbus_we_i,
    input  logic [3:0]           dbus_be_i,
    input  logic [31:0]          dbus_adr_i,
    input  logic [31:0]          dbus_dat_i,
    output logic                 dbus_ack_o,
    output logic [31:0]          dbus_dat_o,
    output logic                 mem_sel_o,
    output logic                 mem_stb_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [MEM_ADR_W-1:0] mem_adr_o,
    output logic [31:0]          mem_dat_o,
    input  logic                 mem_ack_i,
    input  logic [31:0]          mem_dat_i
);

    state_t               state_q, state_n;
    owner_t               owner_q, owner_n;
    owner_t               last_q, last_n;
    req_t                 req_q, req_n, ireq, dreq;
    logic [MEM_ADR_W-1:0] adr_q, adr_n, iadr, dadr;
    logic [DAT_W-1:0]     rdata_q, rdata_n;
    logic                 stb_q, stb_n;
    logic                 iack_q, iack_n;
    logic                 dack_q, dack_n;
    logic                 grant_i, grant_d;
    logic                 hit;
    logic [DAT_W-1:0]     hit_dat;
    logic                 unused_adr;

    assign iadr = ibus_adr_i[MEM_ADR_W+1:2];
    assign dadr = dbus_adr_i[MEM_ADR_W+1:2];
    assign unused_adr = ^{ibus_adr_i, dbus_adr_i};

    // Candidate latch contents for each bus; fetches are always full-word reads.
    always_comb begin
        ireq     = '0;
        ireq.sel = ibus_adr_i[RAM_SEL_BIT];
        ireq.we  = 1'b0;
        ireq.be  = 4'hF;
        dreq     = '0;
        dreq.sel = dbus_adr_i[RAM_SEL_BIT];
        dreq.we  = dbus_we_i;
        dreq.be  = dbus_be_i;
        dreq.dat = dbus_dat_i;
    end

    // Round-robin: on contention the bus not granted last wins.
    assign grant_i = ibus_stb_i && (!dbus_stb_i || (last_q == DBUS));
    assign grant_d = dbus_stb_i && (!ibus_stb_i || (last_q == IBUS));

`ifdef WB_QSPI_ARB_IBUF_EN
    logic fill, inval;

    // Tag carries no region bit, so a RAM write to the same word offset also invalidates.
    assign fill  = (state_q == BUSY) && mem_ack_i && (owner_q == IBUS);
    assign inval = (state_q == BUSY) && mem_ack_i && (owner_q == DBUS) && req_q.we && req_q.sel;

    wb_qspi_ibuf #(
        .TAG_W (MEM_ADR_W)
    ) u_ibuf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .lookup_tag (iadr),
        .hit_c      (hit),
        .hit_dat    (hit_dat),
        .fill       (fill),
        .fill_tag   (adr_q),
        .fill_dat   (mem_dat_i),
        .inval      (inval),
        .inval_tag  (adr_q)
    );
`else
    assign hit     = 1'b0;
    assign hit_dat = '0;
`endif

    // Next-state and next-register values.
    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        last_n  = last_q;
        req_n   = req_q;
        adr_n   = adr_q;
        rdata_n = rdata_q;
        stb_n   = 1'b0;
        iack_n  = 1'b0;
        dack_n  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    owner_n = IBUS;
                    last_n  = IBUS;
                    req_n   = ireq;
                    adr_n   = iadr;
                    if (hit) begin
                        state_n = DONE;
                        rdata_n = hit_dat;
                        iack_n  = 1'b1;
                    end else begin
                        state_n = BUSY;
                        stb_n   = 1'b1;
                    end
                end else if (grant_d) begin
                    owner_n = DBUS;
                    last_n  = DBUS;
                    req_n   = dreq;
                    adr_n   = dadr;
                    if (dreq.we && !dreq.sel) begin
                        state_n = DONE;
                        rdata_n = '0;
                        dack_n  = 1'b1;
                    end else begin
                        state_n = BUSY;
                        stb_n   = 1'b1;
                    end
                end
            end
            BUSY: begin
                stb_n = 1'b1;
                if (mem_ack_i) begin
                    state_n = DONE;
                    stb_n   = 1'b0;
                    rdata_n = mem_dat_i;
                    iack_n  = (owner_q == IBUS);
                    dack_n  = (owner_q == DBUS);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= IBUS;
            last_q  <= IBUS;
            req_q   <= '0;
            adr_q   <= '0;
            rdata_q <= '0;
            stb_q   <= 1'b0;
            iack_q  <= 1'b0;
            dack_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            last_q  <= last_n;
            req_q   <= req_n;
            adr_q   <= adr_n;
            rdata_q <= rdata_n;
            stb_q   <= stb_n;
            iack_q  <= iack_n;
            dack_q  <= dack_n;
        end
    end

    assign mem_stb_o  = stb_q;
    assign mem_sel_o  = req_q.sel;
    assign mem_we_o   = req_q.we;
    assign mem_be_o   = req_q.be;
    assign mem_dat_o  = req_q.dat;
    assign mem_adr_o  = adr_q;
    assign ibus_ack_o = iack_q;
    assign dbus_ack_o = dack_q;
    assign ibus_dat_o = rdata_q;
    assign dbus_dat_o = rdata_q;

endmodule

// File: tb/tb_wb_qspi_arb.sv
// Directed bench for wb_qspi_arb with a simple fixed-latency controller model.
`timescale 1ns/1ps
module tb_wb_qspi_arb;

    localparam int unsigned MEM_ADR_W = 22;

    logic                 clk_i, rst_i;
    logic                 ibus_stb_i, ibus_ack_o;
    logic [31:0]          ibus_adr_i, ibus_dat_o;
    logic                 dbus_stb_i, dbus_we_i, dbus_ack_o;
    logic [3:0]           dbus_be_i;
    logic [31:0]          dbus_adr_i, dbus_dat_i, dbus_dat_o;
    logic                 mem_sel_o, mem_stb_o, mem_we_o, mem_ack_i;
    logic [3:0]           mem_be_o;
    logic [MEM_ADR_W-1:0] mem_adr_o;
    logic [31:0]          mem_dat_o, mem_dat_i;

    int errors = 0;
    int checks = 0;

    // controller model state
    int          lat = 2;
    int          cnt = 0;
    logic        mack = 1'b0;
    logic [31:0] mdat = 32'h0;

    // results of run_req
    int                   r_cyc, r_stbs;
    bit                   r_ok;
    logic [31:0]          r_dat, r_wdat;
    logic                 r_sel, r_we;
    logic [3:0]           r_be;
    logic [MEM_ADR_W-1:0] r_adr, r_ladr;

    wb_qspi_arb dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ibus_stb_i (ibus_stb_i),
        .ibus_adr_i (ibus_adr_i),
        .ibus_ack_o (ibus_ack_o),
        .ibus_dat_o (ibus_dat_o),
        .dbus_stb_i (dbus_stb_i),
        .dbus_we_i  (dbus_we_i),
        .dbus_be_i  (dbus_be_i),
        .dbus_adr_i (dbus_adr_i),
        .dbus_dat_i (dbus_dat_i),
        .dbus_ack_o (dbus_ack_o),
        .dbus_dat_o (dbus_dat_o),
        .mem_sel_o  (mem_sel_o),
        .mem_stb_o  (mem_stb_o),
        .mem_we_o   (mem_we_o),
        .mem_be_o   (mem_be_o),
        .mem_adr_o  (mem_adr_o),
        .mem_dat_o  (mem_dat_o),
        .mem_ack_i  (mem_ack_i),
        .mem_dat_i  (mem_dat_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Controller acks in the lat-th cycle of a held strobe.
    always @(posedge clk_i) begin
        if (rst_i) begin
            cnt  <= 0;
            mack <= 1'b0;
        end else if (mack) begin
            cnt  <= 0;
            mack <= 1'b0;
        end else if (mem_stb_o) begin
            cnt <= cnt + 1;
            if (cnt + 1 == lat - 1) mack <= 1'b1;
        end
    end
    assign mem_ack_i = mack;
    assign mem_dat_i = mack ? mdat : 32'hBAD0_BAD0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Wait for the chosen bus ack, recording strobe cycles and latch contents; drops stb on ack.
    task automatic run_req(input bit is_d, input bit scramble);
        bit done = 1'b0;
        r_cyc = 0; r_stbs = 0; r_dat = 'x; r_sel = 'x; r_adr = 'x; r_we = 'x; r_be = 'x; r_wdat = 'x; r_ladr = 'x;
        while (!done && r_cyc < 200) begin
            @(negedge clk_i);
            r_cyc++;
            if (mem_stb_o) begin
                if (r_stbs == 0) begin
                    r_sel = mem_sel_o; r_adr = mem_adr_o; r_we = mem_we_o; r_be = mem_be_o; r_wdat = mem_dat_o;
                    if (scramble) begin
                        dbus_adr_i = 32'hFFFF_FFFC; dbus_dat_i = 32'hDEAD_BEEF; dbus_be_i = 4'hF;
                    end
                end
                r_stbs++;
                r_ladr = mem_adr_o;
            end
            if (is_d ? dbus_ack_o : ibus_ack_o) begin
                done  = 1'b1;
                r_dat = is_d ? dbus_dat_o : ibus_dat_o;
                if (is_d) begin dbus_stb_i = 1'b0; dbus_we_i = 1'b0; end
                else ibus_stb_i = 1'b0;
            end
        end
        r_ok = done;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk_i); @(negedge clk_i);
        checks++; if ({mem_stb_o, ibus_ack_o, dbus_ack_o} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b want 000", {mem_stb_o, ibus_ack_o, dbus_ack_o}); end
        checks++; if ({mem_sel_o, mem_we_o, mem_be_o} !== 6'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", {mem_sel_o, mem_we_o, mem_be_o}); end
        checks++; if (mem_adr_o !== '0) begin errors++; $display("FAIL reset_adr: got %h want 0", mem_adr_o); end
        checks++; if ({mem_dat_o, ibus_dat_o, dbus_dat_o} !== 96'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", {mem_dat_o, ibus_dat_o, dbus_dat_o}); end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_rom_fetch();
        lat = 20; mdat = 32'h0051_3093;
        ibus_adr_i = 32'h0000_0010; ibus_stb_i = 1'b1;
        run_req(1'b0, 1'b0);
        checks++; if (r_ok !== 1'b1) begin errors++; $display("FAIL t1_ack: no ibus ack within %0d cycles", r_cyc); end
        checks++; if ({r_sel, r_we, r_be} !== 6'b00_1111) begin errors++; $display("FAIL t1_ctl: got sel/we/be %b want 001111", {r_sel, r_we, r_be}); end
        checks++; if (r_adr !== 22'd4) begin errors++; $display("FAIL t1_adr: got %h want 4", r_adr); end
        checks++; if (r_stbs !== 20) begin errors++; $display("FAIL t1_stb_len: got %0d want 20", r_stbs); end
        checks++; if (r_cyc !== 21) begin errors++; $display("FAIL t1_latency: got %0d want 21", r_cyc); end
        checks++; if (r_dat !== 32'h0051_3093) begin errors++; $display("FAIL t1_dat: got %h want 00513093", r_dat); end
        checks++; if (mem_stb_o !== 1'b0) begin errors++; $display("FAIL t1_stb_drop: got %b want 0", mem_stb_o); end
        @(negedge clk_i);
        checks++; if (ibus_ack_o !== 1'b0) begin errors++; $display("FAIL t1_ack_len: got %b want 0", ibus_ack_o); end
    endtask

    task automatic test_simultaneous();
        int cyc = 0, d_at = 0, i_at = 0, gap = 0, periods = 0;
        logic prev = 1'b0, sel1 = 1'bx, sel2 = 1'bx;
        logic [MEM_ADR_W-1:0] adr1 = 'x, adr2 = 'x;
        logic [31:0] dd = 'x, id = 'x;
        lat = 3; mdat = 32'h1234_5678;
        ibus_adr_i = 32'h0000_0040;
        dbus_adr_i = 32'h0100_0008; dbus_we_i = 1'b0; dbus_be_i = 4'hF;
        ibus_stb_i = 1'b1; dbus_stb_i = 1'b1;
        while ((d_at == 0 || i_at == 0) && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            if (mem_stb_o && !prev) begin
                periods++;
                if (periods == 1) begin sel1 = mem_sel_o; adr1 = mem_adr_o; end
                else begin sel2 = mem_sel_o; adr2 = mem_adr_o; end
            end
            if (!mem_stb_o && periods == 1) gap++;
            if (dbus_ack_o && d_at == 0) begin d_at = cyc; dd = dbus_dat_o; dbus_stb_i = 1'b0; end
            if (ibus_ack_o && i_at == 0) begin i_at = cyc; id = ibus_dat_o; ibus_stb_i = 1'b0; end
            prev = mem_stb_o;
        end
        checks++; if (d_at !== 4) begin errors++; $display("FAIL t2_dbus_first: dbus ack at %0d want 4", d_at); end
        checks++; if (i_at !== 9) begin errors++; $display("FAIL t2_ibus_second: ibus ack at %0d want 9", i_at); end
        checks++; if ({sel1, adr1} !== {1'b1, 22'd2}) begin errors++; $display("FAIL t2_first_req: got sel %b adr %h want 1/2", sel1, adr1); end
        checks++; if ({sel2, adr2} !== {1'b0, 22'h10}) begin errors++; $display("FAIL t2_second_req: got sel %b adr %h want 0/10", sel2, adr2); end
        checks++; if (gap > 2 || periods !== 2) begin errors++; $display("FAIL t2_gap: gap %0d periods %0d want <=2 and 2", gap, periods); end
        checks++; if ({dd, id} !== {32'h1234_5678, 32'h1234_5678}) begin errors++; $display("FAIL t2_dat: got %h %h want 12345678", dd, id); end
        @(negedge clk_i);
    endtask

    task automatic test_byte_store();
        lat = 2; mdat = 32'h0;
        dbus_adr_i = 32'h0100_0006; dbus_be_i = 4'b0100; dbus_dat_i = 32'h00AB_0000; dbus_we_i = 1'b1;
        dbus_stb_i = 1'b1;
        run_req(1'b1, 1'b1);
        checks++; if (r_ok !== 1'b1) begin errors++; $display("FAIL t3_ack: no dbus ack within %0d cycles", r_cyc); end
        checks++; if ({r_sel, r_we, r_be} !== 6'b11_0100) begin errors++; $display("FAIL t3_ctl: got sel/we/be %b want 110100", {r_sel, r_we, r_be}); end
        checks++; if (r_adr !== 22'd1) begin errors++; $display("FAIL t3_adr: got %h want 1", r_adr); end
        checks++; if (r_wdat !== 32'h00AB_0000) begin errors++; $display("FAIL t3_wdat: got %h want 00ab0000", r_wdat); end
        checks++; if (r_ladr !== 22'd1) begin errors++; $display("FAIL t3_held: adr changed to %h want 1", r_ladr); end
        checks++; if (r_cyc !== 3) begin errors++; $display("FAIL t3_latency: got %0d want 3", r_cyc); end
        @(negedge clk_i);
    endtask

    task automatic test_rom_write();
        int stb_seen = 0;
        lat = 2; mdat = 32'h5555_AAAA;
        dbus_adr_i = 32'h0000_0100; dbus_be_i = 4'hF; dbus_dat_i = 32'hCAFE_F00D; dbus_we_i = 1'b1;
        dbus_stb_i = 1'b1;
        run_req(1'b1, 1'b0);
        checks++; if (r_ok !== 1'b1) begin errors++; $display("FAIL t4_ack: no dbus ack within %0d cycles", r_cyc); end
        checks++; if (r_cyc !== 1) begin errors++; $display("FAIL t4_latency: ack in cycle %0d of request want 2nd", r_cyc + 1); end
        checks++; if (r_dat !== 32'h0) begin errors++; $display("FAIL t4_dat: got %h want 0", r_dat); end
        repeat (3) begin @(negedge clk_i); if (mem_stb_o || dbus_ack_o) stb_seen++; end
        checks++; if (r_stbs + stb_seen !== 0) begin errors++; $display("FAIL t4_no_stb: got %0d strobe/ack cycles want 0", r_stbs + stb_seen); end
    endtask

    task automatic test_ibuf();
        lat = 2;
        mdat = 32'h1111_0001; ibus_adr_i = 32'h0000_0020; ibus_stb_i = 1'b1;
        run_req(1'b0, 1'b0);
        checks++; if ({r_ok, r_stbs, r_dat} !== {1'b1, 32'd2, 32'h1111_0001}) begin errors++; $display("FAIL t5_fill: ok %b stbs %0d dat %h want 1/2/11110001", r_ok, r_stbs, r_dat); end
        @(negedge clk_i);
        mdat = 32'h2222_0002; ibus_stb_i = 1'b1;
        run_req(1'b0, 1'b0);
`ifdef WB_QSPI_ARB_IBUF_EN
        checks++; if ({r_ok, r_cyc, r_stbs, r_dat} !== {1'b1, 32'd1, 32'd0, 32'h1111_0001}) begin errors++; $display("FAIL t5_hit: ok %b cyc %0d stbs %0d dat %h want 1/1/0/11110001", r_ok, r_cyc, r_stbs, r_dat); end
`else
        checks++; if ({r_ok, r_cyc, r_stbs, r_dat} !== {1'b1, 32'd3, 32'd2, 32'h2222_0002}) begin errors++; $display("FAIL t5_refetch: ok %b cyc %0d stbs %0d dat %h want 1/3/2/22220002", r_ok, r_cyc, r_stbs, r_dat); end
`endif
        @(negedge clk_i);
        dbus_adr_i = 32'h0100_0020; dbus_be_i = 4'hF; dbus_dat_i = 32'h0; dbus_we_i = 1'b1; dbus_stb_i = 1'b1;
        run_req(1'b1, 1'b0);
        checks++; if ({r_ok, r_stbs, r_sel, r_adr} !== {1'b1, 32'd2, 1'b1, 22'h8}) begin errors++; $display("FAIL t5_ram_wr: ok %b stbs %0d sel %b adr %h want 1/2/1/8", r_ok, r_stbs, r_sel, r_adr); end
        @(negedge clk_i);
        mdat = 32'h3333_0003; ibus_stb_i = 1'b1;
        run_req(1'b0, 1'b0);
        checks++; if ({r_ok, r_stbs, r_dat} !== {1'b1, 32'd2, 32'h3333_0003}) begin errors++; $display("FAIL t5_after_inval: ok %b stbs %0d dat %h want 1/2/33330003", r_ok, r_stbs, r_dat); end
        @(negedge clk_i);
    endtask

    task automatic test_reset_busy();
        int stray = 0;
        lat = 10; mdat = 32'h7777_7777;
        ibus_adr_i = 32'h0000_0030; ibus_stb_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++; if (mem_stb_o !== 1'b1) begin errors++; $display("FAIL t6_busy: got stb %b want 1", mem_stb_o); end
        rst_i = 1'b1; ibus_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++; if ({mem_stb_o, ibus_ack_o} !== 2'b00) begin errors++; $display("FAIL t6_abort: got stb/ack %b want 00", {mem_stb_o, ibus_ack_o}); end
        repeat (25) begin @(negedge clk_i); if (mem_stb_o || ibus_ack_o || dbus_ack_o) stray++; end
        checks++; if (stray !== 0) begin errors++; $display("FAIL t6_no_ack: got %0d active cycles want 0", stray); end
        lat = 2; mdat = 32'h4444_0004;
        ibus_adr_i = 32'h0000_0044; ibus_stb_i = 1'b1;
        run_req(1'b0, 1'b0);
        checks++; if ({r_ok, r_cyc, r_adr, r_dat} !== {1'b1, 32'd3, 22'h11, 32'h4444_0004}) begin errors++; $display("FAIL t6_resume: ok %b cyc %0d adr %h dat %h want 1/3/11/44440004", r_ok, r_cyc, r_adr, r_dat); end
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        ibus_stb_i = 1'b0; ibus_adr_i = '0;
        dbus_stb_i = 1'b0; dbus_we_i = 1'b0; dbus_be_i = 4'hF; dbus_adr_i = '0; dbus_dat_i = '0;
        test_reset();
        test_rom_fetch();
        test_simultaneous();
        test_byte_store();
        test_rom_write();
        test_ibuf();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
